// File: rtl/wb_pkg.sv
// Shared types and constants for the handshaked writeback stage.
package wb_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        WAIT_LD = 2'd1,
        HOLD    = 2'd2
    } ws_state_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    localparam int unsigned SRC_ALU  = 0;
    localparam int unsigned SRC_LOAD = 1;
    localparam int unsigned SRC_PC4  = 2;
    localparam int unsigned SRC_IMM  = 3;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load-data aligner: shifts the addressed sub-word down and extends it.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]              rdata,
    input  logic [2:0]                   funct3,
    input  logic [$clog2(XLEN/8)-1:0]    addr_lo,
    output logic [XLEN-1:0]              result
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] b_up;
    logic [XLEN-1:0] h_up;
    logic [XLEN-1:0] w_up;

    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        // Left-justify each sub-word so an arithmetic right shift extends it;
        // at XLEN=32 the word case degenerates to a zero shift.
        b_up = shifted << (XLEN - 8);
        h_up = shifted << (XLEN - 16);
        w_up = shifted << (XLEN - 32);
        case (funct3)
            LB:      result = $unsigned($signed(b_up) >>> (XLEN - 8));
            LH:      result = $unsigned($signed(h_up) >>> (XLEN - 16));
            LW:      result = $unsigned($signed(w_up) >>> (XLEN - 32));
            LBU:     result = b_up >> (XLEN - 8);
            LHU:     result = h_up >> (XLEN - 16);
            LWU:     result = w_up >> (XLEN - 32);
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/wb_stage_hs.sv
// Registered writeback stage: latches MEM payload under valid/allowin, waits for
// late load data, muxes the writeback source and counts retired instructions.
module wb_stage_hs
    import wb_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned NSRC     = 4,
    parameter int unsigned LOAD_SRC = SRC_LOAD,
    parameter int unsigned CNT_W    = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ms_valid,
    output logic                          ws_allowin,
    input  logic                          ms_reg_we,
    input  logic [NSRC-1:0]               ms_src_sel,
    input  logic [REG_AW-1:0]             ms_rd,
    input  logic [NSRC*XLEN-1:0]          ms_src_data,
    input  logic                          ms_is_load,
    input  logic [2:0]                    ms_ld_funct3,
    input  logic [$clog2(XLEN/8)-1:0]     ms_ld_addr_lo,
    input  logic                          ld_rdata_valid,
    input  logic [XLEN-1:0]               ld_rdata,
    output logic                          rf_we,
    output logic [REG_AW-1:0]             rf_waddr,
    output logic [XLEN-1:0]               rf_wdata,
    output logic                          ws_fwd_valid,
    output logic [REG_AW-1:0]             ws_fwd_rd,
    output logic [CNT_W-1:0]              retire_cnt
);

    localparam int unsigned AW = $clog2(XLEN/8);

    ws_state_e               state_q, state_d;
    logic                    reg_we_q, reg_we_d;
    logic [NSRC-1:0]         src_sel_q, src_sel_d;
    logic [REG_AW-1:0]       rd_q, rd_d;
    logic [NSRC*XLEN-1:0]    src_data_q, src_data_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [AW-1:0]           addr_lo_q, addr_lo_d;
    logic [XLEN-1:0]         ld_data_q, ld_data_d;
    logic [CNT_W-1:0]        retire_cnt_q, retire_cnt_d;
    logic                    accept;
    logic [XLEN-1:0]         ld_aligned;

    wb_load_align #(.XLEN(XLEN)) u_align (
        .rdata   (ld_data_q),
        .funct3  (funct3_q),
        .addr_lo (addr_lo_q),
        .result  (ld_aligned)
    );

    always_comb begin
        state_d      = state_q;
        reg_we_d     = reg_we_q;
        src_sel_d    = src_sel_q;
        rd_d         = rd_q;
        src_data_d   = src_data_q;
        funct3_d     = funct3_q;
        addr_lo_d    = addr_lo_q;
        ld_data_d    = ld_data_q;
        retire_cnt_d = retire_cnt_q;

        ws_allowin = (state_q != WAIT_LD);
        accept     = ms_valid & ws_allowin;

        if (state_q == HOLD) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end

        if (accept) begin
            reg_we_d   = ms_reg_we;
            src_sel_d  = ms_src_sel;
            rd_d       = ms_rd;
            src_data_d = ms_src_data;
            funct3_d   = ms_ld_funct3;
            addr_lo_d  = ms_ld_addr_lo;
            if (!ms_is_load) begin
                state_d = HOLD;
            end else if (ld_rdata_valid) begin
                state_d   = HOLD;
                ld_data_d = ld_rdata;
            end else begin
                state_d = WAIT_LD;
            end
        end else if (state_q == WAIT_LD) begin
            if (ld_rdata_valid) begin
                state_d   = HOLD;
                ld_data_d = ld_rdata;
            end
        end else if (state_q == HOLD) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            reg_we_q     <= 1'b0;
            src_sel_q    <= '0;
            rd_q         <= '0;
            src_data_q   <= '0;
            funct3_q     <= '0;
            addr_lo_q    <= '0;
            ld_data_q    <= '0;
            retire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            reg_we_q     <= reg_we_d;
            src_sel_q    <= src_sel_d;
            rd_q         <= rd_d;
            src_data_q   <= src_data_d;
            funct3_q     <= funct3_d;
            addr_lo_q    <= addr_lo_d;
            ld_data_q    <= ld_data_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Multi-hot selects OR their slots together; zero-hot yields zero.
    always_comb begin
        rf_wdata = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (src_sel_q[i]) begin
                rf_wdata = rf_wdata | ((i == LOAD_SRC) ? ld_aligned : src_data_q[i*XLEN +: XLEN]);
            end
        end
    end

    always_comb begin
        rf_we        = (state_q == HOLD) & reg_we_q & (rd_q != '0);
        rf_waddr     = rd_q;
        ws_fwd_valid = (state_q != EMPTY) & reg_we_q & (rd_q != '0);
        ws_fwd_rd    = rd_q;
        retire_cnt   = retire_cnt_q;
    end

endmodule

// File: tb/tb_wb_stage_hs.sv
// Directed-vector bench for wb_stage_hs with hand-computed expectations.
module tb_wb_stage_hs;

    logic         clk = 1'b0;
    logic         rst;
    logic         ms_valid;
    logic         ws_allowin;
    logic         ms_reg_we;
    logic [3:0]   ms_src_sel;
    logic [4:0]   ms_rd;
    logic [127:0] ms_src_data;
    logic         ms_is_load;
    logic [2:0]   ms_ld_funct3;
    logic [1:0]   ms_ld_addr_lo;
    logic         ld_rdata_valid;
    logic [31:0]  ld_rdata;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata;
    logic         ws_fwd_valid;
    logic [4:0]   ws_fwd_rd;
    logic [63:0]  retire_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_stage_hs #(
        .XLEN     (32),
        .REG_AW   (5),
        .NSRC     (4),
        .LOAD_SRC (1),
        .CNT_W    (64)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ms_valid       (ms_valid),
        .ws_allowin     (ws_allowin),
        .ms_reg_we      (ms_reg_we),
        .ms_src_sel     (ms_src_sel),
        .ms_rd          (ms_rd),
        .ms_src_data    (ms_src_data),
        .ms_is_load     (ms_is_load),
        .ms_ld_funct3   (ms_ld_funct3),
        .ms_ld_addr_lo  (ms_ld_addr_lo),
        .ld_rdata_valid (ld_rdata_valid),
        .ld_rdata       (ld_rdata),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .ws_fwd_valid   (ws_fwd_valid),
        .ws_fwd_rd      (ws_fwd_rd),
        .retire_cnt     (retire_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs/outputs are handled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic ld, input logic we, input logic [3:0] sel,
                            input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
        ms_valid      = 1'b1;
        ms_is_load    = ld;
        ms_reg_we     = we;
        ms_src_sel    = sel;
        ms_rd         = rd;
        ms_ld_funct3  = f3;
        ms_ld_addr_lo = lo;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; ms_valid = 1'b0; ms_reg_we = 1'b0; ms_src_sel = '0; ms_rd = '0;
        ms_src_data = '0; ms_is_load = 1'b0; ms_ld_funct3 = '0; ms_ld_addr_lo = '0;
        ld_rdata_valid = 1'b0; ld_rdata = '0;
        step(); step();
        rst = 1'b0;

        // Reset state
        check_eq("rst_rf_we", rf_we, 0);
        check_eq("rst_fwd_valid", ws_fwd_valid, 0);
        check_eq("rst_allowin", ws_allowin, 1);
        check_eq("rst_waddr", rf_waddr, 0);
        check_eq("rst_wdata", rf_wdata, 0);
        check_eq("rst_fwd_rd", ws_fwd_rd, 0);
        check_eq("rst_cnt", retire_cnt, 0);

        // ALU result, no stall
        drive_op(0, 1, 4'b0001, 5'd5, 3'b000, 2'd0);
        ms_src_data[0 +: 32] = 32'h1234;
        step();
        ms_valid = 1'b0;
        check_eq("alu_we", rf_we, 1);
        check_eq("alu_waddr", rf_waddr, 5);
        check_eq("alu_wdata", rf_wdata, 32'h1234);
        check_eq("alu_fwd_valid", ws_fwd_valid, 1);
        check_eq("alu_fwd_rd", ws_fwd_rd, 5);
        step();
        check_eq("alu_cnt", retire_cnt, 1);
        check_eq("alu_empty_we", rf_we, 0);

        // Delayed LB, data 3 cycles late
        drive_op(1, 1, 4'b0010, 5'd7, 3'b000, 2'd2);
        step();
        ms_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("lb_wait_allowin", ws_allowin, 0);
            check_eq("lb_wait_we", rf_we, 0);
            check_eq("lb_wait_fwd", ws_fwd_valid, 1);
            if (i == 2) begin
                ld_rdata_valid = 1'b1;
                ld_rdata       = 32'h0080_0000;
            end
            step();
        end
        ld_rdata_valid = 1'b0;
        ld_rdata       = 32'hDEAD_BEEF;
        check_eq("lb_we", rf_we, 1);
        check_eq("lb_waddr", rf_waddr, 7);
        check_eq("lb_wdata", rf_wdata, 32'hFFFF_FF80);
        step();
        check_eq("lb_cnt", retire_cnt, 2);

        // Same-cycle LHU
        drive_op(1, 1, 4'b0010, 5'd9, 3'b101, 2'd2);
        ld_rdata_valid = 1'b1;
        ld_rdata       = 32'hBEEF_0000;
        step();
        ms_valid = 1'b0; ld_rdata_valid = 1'b0;
        check_eq("lhu_we", rf_we, 1);
        check_eq("lhu_wdata", rf_wdata, 32'h0000_BEEF);
        step();
        check_eq("lhu_cnt", retire_cnt, 3);

        // rd=0 then reg_we=0: no write, no forward, still retires
        drive_op(0, 1, 4'b0001, 5'd0, 3'b000, 2'd0);
        ms_src_data[0 +: 32] = 32'hAAAA;
        step();
        check_eq("rd0_we", rf_we, 0);
        check_eq("rd0_fwd", ws_fwd_valid, 0);
        check_eq("rd0_wdata", rf_wdata, 32'hAAAA);
        drive_op(0, 0, 4'b0001, 5'd3, 3'b000, 2'd0);
        step();
        ms_valid = 1'b0;
        check_eq("nowe_we", rf_we, 0);
        check_eq("nowe_fwd", ws_fwd_valid, 0);
        check_eq("nowe_fwd_rd", ws_fwd_rd, 3);
        step();
        check_eq("nowe_cnt", retire_cnt, 5);

        // Zero-hot and multi-hot selects
        drive_op(0, 1, 4'b0000, 5'd4, 3'b000, 2'd0);
        step();
        check_eq("zhot_wdata", rf_wdata, 0);
        drive_op(0, 1, 4'b1001, 5'd4, 3'b000, 2'd0);
        ms_src_data[0 +: 32]  = 32'h0000_00F0;
        ms_src_data[96 +: 32] = 32'h0000_000F;
        step();
        ms_valid = 1'b0;
        check_eq("mhot_wdata", rf_wdata, 32'hFF);
        step();

        // Back-to-back after a fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_op(0, 1, 4'b0100, 5'(10 + k), 3'b000, 2'd0);
            ms_src_data[64 +: 32] = 32'h100 + k;
            check_eq("b2b_allowin", ws_allowin, 1);
            step();
            check_eq("b2b_we", rf_we, 1);
            check_eq("b2b_waddr", rf_waddr, 10 + k);
            check_eq("b2b_wdata", rf_wdata, 32'h100 + k);
        end
        ms_valid = 1'b0;
        step();
        check_eq("b2b_cnt", retire_cnt, 4);

        // Reset while waiting for load data
        drive_op(1, 1, 4'b0010, 5'd6, 3'b010, 2'd0);
        step();
        ms_valid = 1'b0;
        check_eq("rstld_wait", ws_allowin, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        ld_rdata_valid = 1'b1;
        ld_rdata       = 32'h1357_9BDF;
        step();
        ld_rdata_valid = 1'b0;
        check_eq("rstld_we", rf_we, 0);
        check_eq("rstld_allowin", ws_allowin, 1);
        check_eq("rstld_fwd", ws_fwd_valid, 0);
        check_eq("rstld_cnt", retire_cnt, 0);
        step();
        check_eq("rstld_we2", rf_we, 0);
        check_eq("rstld_cnt2", retire_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
